// File: rtl/sc_button_conditioner_player_pkg.sv
// -----------------------------------------------------------------------------
// sc_button_conditioner_player_pkg
// Shared definitions for the player push-button conditioner:
//   - chState_t : 2-bit debounce channel state encoding
//   - default debounce / synchroniser constants for the 50 MHz board clock
//   - DEBOUNCE_CYCLES_SIM : short debounce window used for simulation
//   - cntWidthOk() : elaboration-time check that a counter can hold
//                    DEBOUNCE_CYCLES-1
// -----------------------------------------------------------------------------
package sc_button_conditioner_player_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } chState_t;

  // 20 ms at 50 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int CNT_WIDTH_DEFAULT       = 20;
  localparam int SYNC_STAGES_DEFAULT     = 2;
  localparam int DEBOUNCE_CYCLES_SIM     = 4;
  localparam int NUM_CHANNELS            = 3;

  // True when a cntWidth-bit counter can represent debounceCycles-1.
  function automatic bit cntWidthOk(input int debounceCycles, input int cntWidth);
    return (longint'(debounceCycles) - 64'sd1) < (64'sd1 <<< cntWidth);
  endfunction

endpackage

// File: rtl/sc_button_conditioner_player_debounce_channel.sv
// -----------------------------------------------------------------------------
// sc_debounce_channel
// One push-button conditioning channel: synchroniser, stable-time counter,
// four-state debounce FSM, clean level output and one-cycle press pulse.
//
// Ports:
//   SC_STATEMACHINEPOINT_CLOCK_50     in  system clock
//   SC_STATEMACHINEPOINT_RESET_InHigh in  asynchronous active-high reset
//   rawButton_InLow                   in  raw bouncing button, active-low, async
//   button_OutLow                     out debounced level, active-low
//   buttonPulse_Out                   out one-cycle pulse per accepted press
//   inRelease_Out                     out high while the FSM is in RELEASED
// -----------------------------------------------------------------------------
module sc_debounce_channel
  import sc_button_conditioner_player_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic rawButton_InLow,
  output logic button_OutLow,
  output logic buttonPulse_Out,
  output logic inRelease_Out
);

  // Parameter sanity: reject configurations that cannot debounce correctly.
  if (DEBOUNCE_CYCLES < 2) begin : gBadDebounceCycles
    $error("sc_debounce_channel: DEBOUNCE_CYCLES must be >= 2");
  end
  if (!cntWidthOk(DEBOUNCE_CYCLES, CNT_WIDTH)) begin : gBadCntWidth
    $error("sc_debounce_channel: CNT_WIDTH cannot hold DEBOUNCE_CYCLES-1");
  end
  if (SYNC_STAGES < 2) begin : gBadSyncStages
    $error("sc_debounce_channel: SYNC_STAGES must be >= 2");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchroniser: resets to 1 so an idle (released) button is seen after reset.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] syncReg;
  logic                   synced;

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      syncReg <= '1;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], rawButton_InLow};
    end
  end

  assign synced = syncReg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM. The counter is cleared on every state change, so it only
  // ever counts inside a WAIT state and can never pass CNT_LAST.
  // ---------------------------------------------------------------------------
  chState_t               stateReg, stateNext;
  logic [CNT_WIDTH-1:0]   cntReg, cntNext;
  logic                   pulseReg, pulseNext;

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      stateReg <= RELEASED;
      cntReg   <= '0;
      pulseReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      pulseReg <= pulseNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    pulseNext = 1'b0;
    case (stateReg)
      RELEASED: begin
        cntNext = '0;
        if (!synced) begin
          stateNext = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (synced) begin
          // Bounce: restart the full window from the released side.
          stateNext = RELEASED;
          cntNext   = '0;
        end else if (cntReg == CNT_LAST) begin
          stateNext = PRESSED;
          cntNext   = '0;
          pulseNext = 1'b1;
        end else begin
          cntNext = cntReg + CNT_WIDTH'(1);
        end
      end
      PRESSED: begin
        cntNext = '0;
        if (synced) begin
          stateNext = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (!synced) begin
          // Glitch while held: back to PRESSED without a new pulse.
          stateNext = PRESSED;
          cntNext   = '0;
        end else if (cntReg == CNT_LAST) begin
          stateNext = RELEASED;
          cntNext   = '0;
        end else begin
          cntNext = cntReg + CNT_WIDTH'(1);
        end
      end
      default: begin
        stateNext = RELEASED;
        cntNext   = '0;
      end
    endcase
  end

  // Level is a pure decode of the state register: low in PRESSED/RELEASE_WAIT.
  assign button_OutLow   = (stateReg == RELEASED) || (stateReg == PRESS_WAIT);
  assign buttonPulse_Out = pulseReg;
  assign inRelease_Out   = (stateReg == RELEASED);

endmodule

// File: rtl/sc_button_conditioner_player.sv
// -----------------------------------------------------------------------------
// sc_button_conditioner_player
// Conditions the three raw active-low player buttons (start, left, right) for
// the point state machine. Each button gets an independent debounce channel;
// there is no arbitration between buttons.
//
// Ports:
//   SC_STATEMACHINEPOINT_CLOCK_50     in  50 MHz system clock
//   SC_STATEMACHINEPOINT_RESET_InHigh in  asynchronous active-high reset
//   rawStart_InLow/rawLeft_InLow/rawRight_InLow
//                                     in  raw bouncing buttons, active-low
//   start_OutLow/left_OutLow/right_OutLow
//                                     out debounced levels, active-low
//   startPulse_Out/leftPulse_Out/rightPulse_Out
//                                     out one-cycle pulse per accepted press
//   allReleased_Out                   out registered "all channels RELEASED"
// -----------------------------------------------------------------------------
module sc_button_conditioner_player
  import sc_button_conditioner_player_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic rawStart_InLow,
  input  logic rawLeft_InLow,
  input  logic rawRight_InLow,
  output logic start_OutLow,
  output logic left_OutLow,
  output logic right_OutLow,
  output logic startPulse_Out,
  output logic leftPulse_Out,
  output logic rightPulse_Out,
  output logic allReleased_Out
);

  // Channel index: 0 = start, 1 = left, 2 = right.
  logic [NUM_CHANNELS-1:0] rawVec;
  logic [NUM_CHANNELS-1:0] levelVec;
  logic [NUM_CHANNELS-1:0] pulseVec;
  logic [NUM_CHANNELS-1:0] inReleaseVec;

  assign rawVec = {rawRight_InLow, rawLeft_InLow, rawStart_InLow};

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : gChannel
    sc_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH),
      .SYNC_STAGES     (SYNC_STAGES)
    ) uChannel (
      .SC_STATEMACHINEPOINT_CLOCK_50     (SC_STATEMACHINEPOINT_CLOCK_50),
      .SC_STATEMACHINEPOINT_RESET_InHigh (SC_STATEMACHINEPOINT_RESET_InHigh),
      .rawButton_InLow                   (rawVec[gi]),
      .button_OutLow                     (levelVec[gi]),
      .buttonPulse_Out                   (pulseVec[gi]),
      .inRelease_Out                     (inReleaseVec[gi])
    );
  end

  assign start_OutLow   = levelVec[0];
  assign left_OutLow    = levelVec[1];
  assign right_OutLow   = levelVec[2];
  assign startPulse_Out = pulseVec[0];
  assign leftPulse_Out  = pulseVec[1];
  assign rightPulse_Out = pulseVec[2];

  // Registered copy of the channel states; lags the channel FSMs by a cycle.
  logic allReleasedReg;

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      allReleasedReg <= 1'b1;
    end else begin
      allReleasedReg <= &inReleaseVec;
    end
  end

  assign allReleased_Out = allReleasedReg;

endmodule
